// File: rtl/axi4_req_master.sv
// Single-outstanding AXI4 burst master: turns one command plus a write-beat or
// read-beat stream into AW/W/B or AR/R channel traffic with INCR bursts.
module axi4_req_master #(
  parameter logic [1:0] AXI_BURST = 2'b01,
  parameter logic [3:0] AXI_ID    = 4'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // command side
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [7:0]  req_len_i,
  output logic        req_ready_o,
  // write beat stream
  input  logic        wdata_valid_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic        wdata_ready_o,
  // read beat stream
  output logic        rdata_valid_o,
  output logic [31:0] rdata_o,
  output logic        rdata_last_o,
  output logic        rdata_error_o,
  input  logic        rdata_ready_i,
  // write completion
  output logic        wresp_valid_o,
  output logic        wresp_error_o,
  // AXI4 write address
  output logic        axi_awvalid_o,
  output logic [31:0] axi_awaddr_o,
  output logic [3:0]  axi_awid_o,
  output logic [7:0]  axi_awlen_o,
  output logic [1:0]  axi_awburst_o,
  input  logic        axi_awready_i,
  // AXI4 write data
  output logic        axi_wvalid_o,
  output logic [31:0] axi_wdata_o,
  output logic [3:0]  axi_wstrb_o,
  output logic        axi_wlast_o,
  input  logic        axi_wready_i,
  // AXI4 write response
  input  logic        axi_bvalid_i,
  input  logic [1:0]  axi_bresp_i,
  input  logic [3:0]  axi_bid_i,
  output logic        axi_bready_o,
  // AXI4 read address
  output logic        axi_arvalid_o,
  output logic [31:0] axi_araddr_o,
  output logic [3:0]  axi_arid_o,
  output logic [7:0]  axi_arlen_o,
  output logic [1:0]  axi_arburst_o,
  input  logic        axi_arready_i,
  // AXI4 read data
  input  logic        axi_rvalid_i,
  input  logic [31:0] axi_rdata_i,
  input  logic [1:0]  axi_rresp_i,
  input  logic [3:0]  axi_rid_i,
  input  logic        axi_rlast_i,
  output logic        axi_rready_o
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR,
    WR_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  // Low through reset so req_ready_o stays 0 until the first edge after release.
  logic        out_en_q;

  logic        wlast;
  logic        aw_hs;
  logic        w_hs;

  // Only one transaction is in flight, so both address channels share the
  // registered command, and the stream data passes straight through.
  assign axi_awaddr_o  = addr_q;
  assign axi_awlen_o   = len_q;
  assign axi_awid_o    = AXI_ID;
  assign axi_awburst_o = AXI_BURST;
  assign axi_araddr_o  = addr_q;
  assign axi_arlen_o   = len_q;
  assign axi_arid_o    = AXI_ID;
  assign axi_arburst_o = AXI_BURST;
  assign axi_wdata_o   = wdata_i;
  assign axi_wstrb_o   = wstrb_i;
  assign rdata_o       = axi_rdata_i;

  // Response IDs are not checked: with one outstanding transaction they carry
  // no information.
  logic unused_ids;
  assign unused_ids = ^{axi_bid_i, axi_rid_i};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; the reset is synchronous, so it lives inside the edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      wcnt_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      out_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      wcnt_q    <= wcnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      out_en_q  <= 1'b1;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    wcnt_d        = wcnt_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    req_ready_o   = 1'b0;
    wdata_ready_o = 1'b0;
    rdata_valid_o = 1'b0;
    rdata_last_o  = 1'b0;
    rdata_error_o = 1'b0;
    wresp_valid_o = 1'b0;
    wresp_error_o = 1'b0;
    axi_awvalid_o = 1'b0;
    axi_wvalid_o  = 1'b0;
    axi_wlast_o   = 1'b0;
    axi_bready_o  = 1'b0;
    axi_arvalid_o = 1'b0;
    axi_rready_o  = 1'b0;
    wlast         = 1'b0;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_o = out_en_q;
        if (req_valid_i && out_en_q) begin
          addr_d    = req_addr_i;
          len_d     = req_len_i;
          wcnt_d    = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_write_i ? WR : RD_ADDR;
        end
      end

      RD_ADDR: begin
        axi_arvalid_o = 1'b1;
        if (axi_arready_i) state_d = RD_DATA;
      end

      RD_DATA: begin
        // The slave's rlast ends the burst, whatever the requested length was.
        rdata_valid_o = axi_rvalid_i;
        axi_rready_o  = rdata_ready_i;
        rdata_last_o  = axi_rlast_i;
        rdata_error_o = (axi_rresp_i != 2'b00);
        if (axi_rvalid_i && rdata_ready_i && axi_rlast_i) state_d = IDLE;
      end

      WR: begin
        // AW and W progress independently; the burst is done once both are.
        wlast         = !w_done_q && (wcnt_q == len_q);
        axi_awvalid_o = !aw_done_q;
        axi_wvalid_o  = !w_done_q && wdata_valid_i;
        wdata_ready_o = !w_done_q && axi_wready_i;
        axi_wlast_o   = wlast;
        aw_hs         = !aw_done_q && axi_awready_i;
        w_hs          = !w_done_q && wdata_valid_i && axi_wready_i;
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs) begin
          if (wlast) w_done_d = 1'b1;
          else       wcnt_d   = wcnt_q + 8'd1;
        end
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end

      WR_RESP: begin
        axi_bready_o = 1'b1;
        if (axi_bvalid_i) begin
          wresp_valid_o = 1'b1;
          wresp_error_o = (axi_bresp_i != 2'b00);
          state_d       = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_req_master.sv
// Scoreboard bench for axi4_req_master: the bench plays requester and AXI slave,
// queues the expected channel traffic, and a negedge monitor checks it.
module tb_axi4_req_master;

  localparam logic [3:0] TB_ID    = 4'd5;
  localparam logic [1:0] TB_BURST = 2'b01;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_write_i, req_ready_o;
  logic [31:0] req_addr_i;
  logic [7:0]  req_len_i;
  logic        wdata_valid_i, wdata_ready_o;
  logic [31:0] wdata_i;
  logic [3:0]  wstrb_i;
  logic        rdata_valid_o, rdata_last_o, rdata_error_o, rdata_ready_i;
  logic [31:0] rdata_o;
  logic        wresp_valid_o, wresp_error_o;
  logic        axi_awvalid_o, axi_awready_i;
  logic [31:0] axi_awaddr_o;
  logic [3:0]  axi_awid_o;
  logic [7:0]  axi_awlen_o;
  logic [1:0]  axi_awburst_o;
  logic        axi_wvalid_o, axi_wlast_o, axi_wready_i;
  logic [31:0] axi_wdata_o;
  logic [3:0]  axi_wstrb_o;
  logic        axi_bvalid_i, axi_bready_o;
  logic [1:0]  axi_bresp_i;
  logic [3:0]  axi_bid_i;
  logic        axi_arvalid_o, axi_arready_i;
  logic [31:0] axi_araddr_o;
  logic [3:0]  axi_arid_o;
  logic [7:0]  axi_arlen_o;
  logic [1:0]  axi_arburst_o;
  logic        axi_rvalid_i, axi_rlast_i, axi_rready_o;
  logic [31:0] axi_rdata_i;
  logic [1:0]  axi_rresp_i;
  logic [3:0]  axi_rid_i;

  axi4_req_master #(.AXI_BURST(TB_BURST), .AXI_ID(TB_ID)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_len_i(req_len_i), .req_ready_o(req_ready_o),
    .wdata_valid_i(wdata_valid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
    .wdata_ready_o(wdata_ready_o),
    .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o), .rdata_last_o(rdata_last_o),
    .rdata_error_o(rdata_error_o), .rdata_ready_i(rdata_ready_i),
    .wresp_valid_o(wresp_valid_o), .wresp_error_o(wresp_error_o),
    .axi_awvalid_o(axi_awvalid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awid_o(axi_awid_o),
    .axi_awlen_o(axi_awlen_o), .axi_awburst_o(axi_awburst_o), .axi_awready_i(axi_awready_i),
    .axi_wvalid_o(axi_wvalid_o), .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o),
    .axi_wlast_o(axi_wlast_o), .axi_wready_i(axi_wready_i),
    .axi_bvalid_i(axi_bvalid_i), .axi_bresp_i(axi_bresp_i), .axi_bid_i(axi_bid_i),
    .axi_bready_o(axi_bready_o),
    .axi_arvalid_o(axi_arvalid_o), .axi_araddr_o(axi_araddr_o), .axi_arid_o(axi_arid_o),
    .axi_arlen_o(axi_arlen_o), .axi_arburst_o(axi_arburst_o), .axi_arready_i(axi_arready_i),
    .axi_rvalid_i(axi_rvalid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
    .axi_rid_i(axi_rid_i), .axi_rlast_i(axi_rlast_i), .axi_rready_o(axi_rready_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } cmd_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        err;
  } rbeat_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } wbeat_t;

  cmd_t   exp_ar[$];
  cmd_t   exp_aw[$];
  rbeat_t exp_r[$];
  wbeat_t exp_w[$];
  logic   exp_b[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every DUT-side handshake is compared against the scoreboard queues.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (axi_arvalid_o) begin
        check("ar_expected", 64'(exp_ar.size() != 0), 64'(1));
        if (exp_ar.size() != 0) begin
          check("ar_fields", 64'({axi_arid_o, axi_arburst_o, axi_araddr_o, axi_arlen_o}),
                64'({TB_ID, TB_BURST, exp_ar[0].addr, exp_ar[0].len}));
          if (axi_arready_i) void'(exp_ar.pop_front());
        end
      end
      if (axi_awvalid_o) begin
        check("aw_expected", 64'(exp_aw.size() != 0), 64'(1));
        if (exp_aw.size() != 0) begin
          check("aw_fields", 64'({axi_awid_o, axi_awburst_o, axi_awaddr_o, axi_awlen_o}),
                64'({TB_ID, TB_BURST, exp_aw[0].addr, exp_aw[0].len}));
          if (axi_awready_i) void'(exp_aw.pop_front());
        end
      end
      if (axi_wvalid_o && axi_wready_i) begin
        check("w_expected", 64'(exp_w.size() != 0), 64'(1));
        if (exp_w.size() != 0) begin
          check("w_beat", 64'({axi_wdata_o, axi_wstrb_o, axi_wlast_o}), 64'(exp_w[0]));
          void'(exp_w.pop_front());
        end
      end
      if (rdata_valid_o) begin
        check("rready_mirror", 64'(axi_rready_o), 64'(rdata_ready_i));
        if (rdata_ready_i) begin
          check("r_expected", 64'(exp_r.size() != 0), 64'(1));
          if (exp_r.size() != 0) begin
            check("r_beat", 64'({rdata_o, rdata_last_o, rdata_error_o}), 64'(exp_r[0]));
            void'(exp_r.pop_front());
          end
        end
      end
      if (wresp_valid_o) begin
        check("b_expected", 64'(exp_b.size() != 0), 64'(1));
        if (exp_b.size() != 0) begin
          check("wresp_error", 64'(wresp_error_o), 64'(exp_b[0]));
          void'(exp_b.pop_front());
        end
      end
    end
  end

  task automatic issue_req(input logic wr, input logic [31:0] addr, input logic [7:0] len);
    int g;
    g = 0;
    while (!req_ready_o && g < 100) begin
      step();
      g++;
    end
    check("req_ready_timeout", 64'(g < 100), 64'(1));
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_len_i   = len;
    if (wr) exp_aw.push_back(cmd_t'{addr: addr, len: len});
    else    exp_ar.push_back(cmd_t'{addr: addr, len: len});
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic ar_accept(input int delay);
    int g;
    g = 0;
    while (!axi_arvalid_o && g < 50) begin
      step();
      g++;
    end
    check("arvalid_timeout", 64'(g < 50), 64'(1));
    repeat (delay) step();
    axi_arready_i = 1'b1;
    step();
    axi_arready_i = 1'b0;
  endtask

  // err_beat >= 0: only that beat returns SLVERR; -1: all OKAY; -2: random.
  // ready_mode 0: always ready; 1: random; 2: toggles 1-0-1-0.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input int ar_delay,
                         input int nbeats, input int ready_mode, input int err_beat);
    logic [31:0] d;
    logic [1:0]  resp;
    bit          rdy;
    int          k, g;
    issue_req(1'b0, addr, len);
    ar_accept(ar_delay);
    k = 0;
    for (int b = 0; b < nbeats; b++) begin
      d = $urandom;
      if (err_beat >= 0)       resp = (b == err_beat) ? 2'b10 : 2'b00;
      else if (err_beat == -2) resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      else                     resp = 2'b00;
      axi_rvalid_i = 1'b1;
      axi_rdata_i  = d;
      axi_rresp_i  = resp;
      axi_rlast_i  = (b == nbeats - 1);
      axi_rid_i    = TB_ID;
      g = 0;
      do begin
        case (ready_mode)
          0:       rdy = 1'b1;
          1:       rdy = 1'($urandom_range(0, 1));
          default: rdy = (k % 2 == 0);
        endcase
        k++;
        g++;
        rdata_ready_i = rdy;
        if (rdy) exp_r.push_back(rbeat_t'{data: d, last: axi_rlast_i, err: (resp != 2'b00)});
        step();
      end while (!rdy && g < 100);
    end
    axi_rvalid_i  = 1'b0;
    axi_rlast_i   = 1'b0;
    rdata_ready_i = 1'b0;
    check("rd_back_to_idle", 64'(req_ready_o), 64'(1));
  endtask

  // wmode 0: stream and slave always ready; 1: random valid/ready and strobes.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input int aw_delay,
                          input int wmode, input logic [31:0] base, input logic [3:0] strb,
                          input logic [1:0] bresp, input int b_delay);
    logic [31:0] dat[$];
    logic [3:0]  stb[$];
    logic [31:0] d;
    logic [3:0]  s;
    bit          aw_done, hs_aw, hs_w;
    int          beat, cyc;
    for (int i = 0; i <= int'(len); i++) begin
      d = base ^ (32'(i) * 32'h9E37_79B9);
      s = (wmode != 0) ? 4'($urandom) : strb;
      dat.push_back(d);
      stb.push_back(s);
      exp_w.push_back(wbeat_t'{data: d, strb: s, last: (i == int'(len))});
    end
    issue_req(1'b1, addr, len);
    aw_done = 1'b0;
    beat    = 0;
    cyc     = 0;
    while (!(aw_done && beat > int'(len)) && cyc < 400) begin
      axi_awready_i = (cyc >= aw_delay);
      if (beat <= int'(len)) begin
        wdata_valid_i = (wmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        wdata_i       = dat[beat];
        wstrb_i       = stb[beat];
      end else begin
        wdata_valid_i = 1'b0;
      end
      axi_wready_i = (wmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk_i);
      if (beat > int'(len)) begin
        check("wready_after_last", 64'(wdata_ready_o), 64'(0));
        if (!aw_done) check("bready_before_aw", 64'(axi_bready_o), 64'(0));
      end
      hs_aw = axi_awvalid_o && axi_awready_i;
      hs_w  = wdata_valid_i && wdata_ready_o;
      step();
      cyc++;
      if (hs_aw) aw_done = 1'b1;
      if (hs_w)  beat++;
    end
    check("wr_timeout", 64'(cyc < 400), 64'(1));
    axi_awready_i = 1'b0;
    wdata_valid_i = 1'b0;
    axi_wready_i  = 1'b0;
    repeat (b_delay) step();
    check("bready_in_resp", 64'(axi_bready_o), 64'(1));
    axi_bvalid_i = 1'b1;
    axi_bresp_i  = bresp;
    axi_bid_i    = TB_ID;
    exp_b.push_back(bresp != 2'b00);
    step();
    axi_bvalid_i = 1'b0;
    check("wr_back_to_idle", 64'(req_ready_o), 64'(1));
  endtask

  function automatic logic [10:0] ctrl_outs();
    return {req_ready_o, wdata_ready_o, rdata_valid_o, rdata_last_o, wresp_valid_o,
            axi_awvalid_o, axi_wvalid_o, axi_wlast_o, axi_bready_o, axi_arvalid_o, axi_rready_o};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] addr;
    logic [7:0]  len;
    int          nb, sel;

    // Reset with every upstream valid/ready driven high to prove the outputs are gated.
    rst_i = 1'b0;
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = '0; req_len_i = '0;
    wdata_valid_i = 1'b1; wdata_i = '0; wstrb_i = '0;
    rdata_ready_i = 1'b1;
    axi_awready_i = 1'b1; axi_wready_i = 1'b1;
    axi_bvalid_i = 1'b1; axi_bresp_i = '0; axi_bid_i = '0;
    axi_arready_i = 1'b1;
    axi_rvalid_i = 1'b1; axi_rdata_i = '0; axi_rresp_i = '0; axi_rid_i = '0; axi_rlast_i = 1'b1;
    repeat (3) step();
    check("reset_outputs", 64'(ctrl_outs()), 64'(0));
    req_valid_i = 1'b0; wdata_valid_i = 1'b0; rdata_ready_i = 1'b0;
    axi_awready_i = 1'b0; axi_wready_i = 1'b0; axi_bvalid_i = 1'b0;
    axi_arready_i = 1'b0; axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0;
    mon_en = 1'b1;
    rst_i  = 1'b1;
    step();
    check("ready_after_release", 64'(req_ready_o), 64'(1));

    // Directed scenarios.
    do_read(32'h0000_1000, 8'd3, 2, 4, 0, -1);
    do_write(32'h0000_0020, 8'd0, 0, 0, 32'hDEAD_BEEF, 4'hF, 2'b00, 1);
    do_write(32'h0000_0100, 8'd7, 20, 0, $urandom, 4'hF, 2'b00, 2);
    do_read(32'h0000_2000, 8'd3, 0, 4, 2, 1);
    do_write(32'h0000_0040, 8'd3, 2, 0, $urandom, 4'h3, 2'b10, 0);
    do_read(32'h0000_2100, 8'd5, 0, 3, 0, -1);
    do_read(32'h0000_2200, 8'd1, 1, 4, 0, -1);
    do_read(32'h0000_2300, 8'd0, 0, 1, 1, -1);

    // Reset during beat 3 of an 8-beat read.
    issue_req(1'b0, 32'h0000_3000, 8'd7);
    ar_accept(0);
    for (int b = 0; b < 2; b++) begin
      axi_rvalid_i = 1'b1; axi_rdata_i = $urandom; axi_rresp_i = 2'b00;
      axi_rlast_i = 1'b0; axi_rid_i = TB_ID; rdata_ready_i = 1'b1;
      exp_r.push_back(rbeat_t'{data: axi_rdata_i, last: 1'b0, err: 1'b0});
      step();
    end
    axi_rdata_i = $urandom;
    rdata_ready_i = 1'b0;
    step();
    rst_i = 1'b0;
    axi_rvalid_i = 1'b0;
    step();
    check("abort_outputs", 64'(ctrl_outs()), 64'(0));
    rst_i = 1'b1;
    step();
    check("ready_after_abort", 64'(req_ready_o), 64'(1));
    do_read(32'h0000_3100, 8'd2, 1, 3, 1, -1);

    // Randomized mix of reads (with on-time, early and late rlast) and writes.
    for (int t = 0; t < 40; t++) begin
      addr = $urandom & 32'hFFFF_FFFC;
      len  = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        nb  = int'(len) + 1;
        sel = $urandom_range(0, 4);
        if (sel == 0 && len > 0) nb = $urandom_range(1, int'(len));
        if (sel == 1)            nb = int'(len) + 1 + $urandom_range(1, 3);
        do_read(addr, len, $urandom_range(0, 3), nb, 1, -2);
      end else begin
        do_write(addr, len, $urandom_range(0, 12), 1, $urandom, 4'hF,
                 2'($urandom_range(0, 3)), $urandom_range(0, 3));
      end
    end

    repeat (3) step();
    check("ar_drained", 64'(exp_ar.size()), 64'(0));
    check("aw_drained", 64'(exp_aw.size()), 64'(0));
    check("w_drained",  64'(exp_w.size()),  64'(0));
    check("r_drained",  64'(exp_r.size()),  64'(0));
    check("b_drained",  64'(exp_b.size()),  64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
